uart_rx_deserializer: RTL and testbench

//  Parametrised serial-to-parallel frame deserializer for the UART receive path.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_shift_reg.sv | 35 +++
 rtl/uart_rx_deserializer.sv | 140 ++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, parity mode constants, counter width helper.
package uart_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } uart_state_e;

  // Parity sense values, common to the RX deserializer and the TX serializer.
  localparam bit UART_PAR_EVEN = 1'b0;
  localparam bit UART_PAR_ODD  = 1'b1;

  // Width of a counter that must hold every value from 0 to nbits inclusive.
  function automatic int unsigned uart_cnt_width(input int unsigned nbits);
    return $clog2(nbits + 1);
  endfunction

endpackage

// File: rtl/uart_shift_reg.sv
// Serial-in shift register; LSB_FIRST=1 enters at the MSB and shifts right,
// LSB_FIRST=0 enters at the LSB and shifts left.
module uart_shift_reg #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q, q_d;

  // Shift operators rather than concatenation so WIDTH=1 needs no special case.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = LSB_FIRST ? ((q_q >> 1) | (WIDTH'(sin) << (WIDTH - 1)))
                      : ((q_q << 1) | WIDTH'(sin));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) q_q <= '0;
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: strobed serial-to-parallel conversion with a valid/ready
// output word and sticky overrun. Define UART_RX_PARITY_EN for a trailing parity bit.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter bit          LSB_FIRST = 1'b1,
  parameter bit          PAR_ODD   = UART_PAR_EVEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sample_en,
  input  logic              sin,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              overrun,
  input  logic              ovr_clr
`ifdef UART_RX_PARITY_EN
  ,
  output logic              parity_err
`endif
);

`ifdef UART_RX_PARITY_EN
  localparam int unsigned NBITS = DATA_W + 1;
`else
  localparam int unsigned NBITS = DATA_W;
`endif
  localparam int unsigned CNT_W = uart_cnt_width(NBITS);

  uart_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;
  logic              perr_q, perr_d;

  logic [NBITS-1:0]  sr_q;
  logic [NBITS-1:0]  frame;
  logic [DATA_W-1:0] word;
  logic              par_bit;
  logic              sr_clr, sr_en, last, complete;

  assign sr_clr   = (state_q == IDLE) && start;
  assign sr_en    = (state_q == SHIFT) && sample_en;
  assign last     = (cnt_q == CNT_W'(NBITS - 1));
  assign complete = sr_en && last;

  uart_shift_reg #(
    .WIDTH    (NBITS),
    .LSB_FIRST(LSB_FIRST)
  ) u_shift (
    .clk(clk),
    .rst(rst),
    .clr(sr_clr),
    .en (sr_en),
    .sin(sin),
    .q  (sr_q)
  );

  // The final bit is shifted in on the same edge the word is captured, so the
  // complete frame is formed here from the register contents plus sin.
  assign frame   = LSB_FIRST ? ((sr_q >> 1) | (NBITS'(sin) << (NBITS - 1)))
                             : ((sr_q << 1) | NBITS'(sin));
  assign word    = LSB_FIRST ? frame[DATA_W-1:0] : frame[NBITS-1 -: DATA_W];
  assign par_bit = LSB_FIRST ? frame[NBITS-1] : frame[0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (sample_en) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear precedes set so a completion coinciding with ovr_clr keeps overrun high.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    perr_d  = perr_q;
    if (valid_q && data_ready) valid_d = 1'b0;
    if (ovr_clr) ovr_d = 1'b0;
    if (complete) begin
      if (valid_q && !data_ready) begin
        ovr_d = 1'b1;
      end else begin
        data_d  = word;
        valid_d = 1'b1;
        perr_d  = (^word) ^ par_bit ^ PAR_ODD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      perr_q  <= perr_d;
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign busy       = (state_q == SHIFT);
  assign overrun    = ovr_q;

`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  logic unused_perr;
  assign unused_perr = perr_q ^ par_bit;
`endif

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench: LSB-first and MSB-first instances share one stimulus stream.
module tb_uart_rx_deserializer;

  localparam int unsigned DW = 8;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned NB = DW + 1;
`else
  localparam int unsigned NB = DW;
`endif

  logic clk = 1'b0;
  logic rst, start, sample_en, sin, data_ready, ovr_clr;
  logic [DW-1:0] data_l, data_m;
  logic valid_l, valid_m, busy_l, busy_m, ovr_l, ovr_m;
`ifdef UART_RX_PARITY_EN
  logic perr_l, perr_m;
`endif

  always #5 clk = ~clk;

  uart_rx_deserializer #(.DATA_W(DW), .LSB_FIRST(1'b1), .PAR_ODD(1'b0)) dut_l (
    .clk(clk), .rst(rst), .start(start), .sample_en(sample_en), .sin(sin),
    .data(data_l), .data_valid(valid_l), .data_ready(data_ready),
    .busy(busy_l), .overrun(ovr_l), .ovr_clr(ovr_clr)
`ifdef UART_RX_PARITY_EN
    , .parity_err(perr_l)
`endif
  );

  uart_rx_deserializer #(.DATA_W(DW), .LSB_FIRST(1'b0), .PAR_ODD(1'b0)) dut_m (
    .clk(clk), .rst(rst), .start(start), .sample_en(sample_en), .sin(sin),
    .data(data_m), .data_valid(valid_m), .data_ready(data_ready),
    .busy(busy_m), .overrun(ovr_m), .ovr_clr(ovr_clr)
`ifdef UART_RX_PARITY_EN
    , .parity_err(perr_m)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: frame = list of received bits, word assembled arithmetically.
  bit        m_busy, m_valid, m_ovr, m_perr;
  bit [7:0]  m_dl, m_dm;
  bit        bits_q[$];

  function automatic bit [7:0] asm_word(input bit lsb_first);
    bit [7:0] w = '0;
    for (int i = 0; i < DW; i++) begin
      if (lsb_first) w = w + (8'(bits_q[i]) << i);
      else           w = w + (8'(bits_q[i]) << (DW - 1 - i));
    end
    return w;
  endfunction

  task automatic step();
    bit done;
    bit nv;
    @(posedge clk);
    done = 1'b0;
    if (!rst) begin
      m_busy = 0; m_valid = 0; m_ovr = 0; m_perr = 0; m_dl = '0; m_dm = '0;
      bits_q.delete();
    end else begin
      if (!m_busy) begin
        if (start) begin
          m_busy = 1'b1;
          bits_q.delete();
        end
      end else if (sample_en) begin
        bits_q.push_back(sin);
        if (bits_q.size() == NB) begin
          done   = 1'b1;
          m_busy = 1'b0;
        end
      end
      nv = m_valid;
      if (m_valid && data_ready) nv = 1'b0;
      if (ovr_clr) m_ovr = 1'b0;
      if (done) begin
        if (m_valid && !data_ready) m_ovr = 1'b1;
        else begin
          m_dl = asm_word(1'b1);
          m_dm = asm_word(1'b0);
          nv   = 1'b1;
          m_perr = (^asm_word(1'b1)) ^ bits_q[NB-1];
        end
      end
      m_valid = nv;
    end
    #1;
  endtask

  task automatic check_model();
    chk("valid_l", 16'(valid_l), 16'(m_valid));
    chk("valid_m", 16'(valid_m), 16'(m_valid));
    chk("busy_l",  16'(busy_l),  16'(m_busy));
    chk("busy_m",  16'(busy_m),  16'(m_busy));
    chk("ovr_l",   16'(ovr_l),   16'(m_ovr));
    chk("ovr_m",   16'(ovr_m),   16'(m_ovr));
    chk("data_l",  16'(data_l),  16'(m_dl));
    chk("data_m",  16'(data_m),  16'(m_dm));
`ifdef UART_RX_PARITY_EN
    chk("perr_l",  16'(perr_l),  16'(m_perr));
    chk("perr_m",  16'(perr_m),  16'(m_perr));
`endif
  endtask

  task automatic idle_inputs();
    start = 0; sample_en = 0; sin = 0; data_ready = 0; ovr_clr = 0; rst = 1;
  endtask

  task automatic send_frame(input logic [7:0] w, input bit par_flip, input bit rdy_last);
    idle_inputs();
    start = 1;
    step(); check_model();
    start = 0;
    for (int i = 0; i < NB; i++) begin
      repeat ($urandom_range(0, 2)) begin
        idle_inputs();
        step(); check_model();
      end
      sample_en  = 1;
      sin        = (i < DW) ? w[i] : ((^w) ^ par_flip);
      data_ready = (i == NB - 1) ? rdy_last : 1'b0;
      step(); check_model();
      idle_inputs();
    end
  endtask

  typedef struct {
    bit rst_n, st, se, si, rdy, clr;
    bit e_valid, e_busy, e_ovr;
    logic [7:0] e_dl, e_dm;
  } vec_t;

  vec_t tbl[20];

  initial begin
    logic [7:0] pat;
    idle_inputs();
    rst = 0;
    step();

`ifndef UART_RX_PARITY_EN
    // Frame 0xA5 with strobes every cycle, accept, then a frame whose start
    // coincides with a strobe that must not be shifted in.
    pat = 8'hA5;
    tbl[0]  = '{0,0,0,0,0,0, 0,0,0, 8'h00, 8'h00};
    tbl[1]  = '{1,1,0,0,0,0, 0,1,0, 8'h00, 8'h00};
    for (int k = 0; k < 8; k++)
      tbl[2+k] = '{1,0,1,pat[k],0,0, (k == 7), (k != 7), 0,
                   (k == 7) ? 8'hA5 : 8'h00, (k == 7) ? 8'hA5 : 8'h00};
    tbl[10] = '{1,0,0,0,1,0, 0,0,0, 8'hA5, 8'hA5};
    tbl[11] = '{1,1,1,1,0,0, 0,1,0, 8'hA5, 8'hA5};
    for (int k = 12; k < 19; k++)
      tbl[k] = '{1,0,1,0,0,0, 0,1,0, 8'hA5, 8'hA5};
    tbl[19] = '{1,0,1,1,0,0, 1,0,0, 8'h80, 8'h01};

    for (int i = 0; i < 20; i++) begin
      rst = tbl[i].rst_n; start = tbl[i].st; sample_en = tbl[i].se;
      sin = tbl[i].si; data_ready = tbl[i].rdy; ovr_clr = tbl[i].clr;
      step();
      chk("tbl_valid_l", 16'(valid_l), 16'(tbl[i].e_valid));
      chk("tbl_valid_m", 16'(valid_m), 16'(tbl[i].e_valid));
      chk("tbl_busy",    16'(busy_l),  16'(tbl[i].e_busy));
      chk("tbl_ovr",     16'(ovr_l),   16'(tbl[i].e_ovr));
      chk("tbl_data_l",  16'(data_l),  16'(tbl[i].e_dl));
      chk("tbl_data_m",  16'(data_m),  16'(tbl[i].e_dm));
    end
`else
    pat = 8'h00;
    chk("reset_valid", 16'(valid_l), 16'(pat[0]));
`endif

    // Overrun: second frame arrives with first word unaccepted.
    idle_inputs(); rst = 0; step(); check_model();
    send_frame(8'h3C, 1'b0, 1'b0);
    chk("ovr_first_data", 16'(data_l), 16'h3C);
    send_frame(8'hC3, 1'b0, 1'b0);
    chk("ovr_kept_data", 16'(data_l), 16'h3C);
    chk("ovr_set", 16'(ovr_l), 16'h1);
    idle_inputs(); ovr_clr = 1; step(); check_model();
    chk("ovr_cleared", 16'(ovr_l), 16'h0);
    idle_inputs(); data_ready = 1; step(); check_model();
    chk("ready_drops_valid", 16'(valid_l), 16'h0);

    // Completion in the same cycle as acceptance.
    send_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b1);
    chk("same_cycle_data", 16'(data_m), 16'hC3);
    chk("same_cycle_valid", 16'(valid_m), 16'h1);
    chk("same_cycle_ovr", 16'(ovr_m), 16'h0);

    // Reset mid-frame discards the partial word.
    idle_inputs(); start = 1; step(); check_model();
    for (int i = 0; i < 4; i++) begin
      idle_inputs(); sample_en = 1; sin = 1; step(); check_model();
    end
    idle_inputs(); rst = 0; step(); check_model();
    chk("midreset_busy", 16'(busy_l), 16'h0);
    chk("midreset_valid", 16'(valid_l), 16'h0);
    send_frame(8'h5A, 1'b0, 1'b0);
    chk("after_reset_data", 16'(data_l), 16'h5A);
    chk("after_reset_ovr", 16'(ovr_l), 16'h0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'hA5, 1'b0, 1'b1);
    chk("parity_ok", 16'(perr_l), 16'h0);
    send_frame(8'hA5, 1'b1, 1'b1);
    chk("parity_bad", 16'(perr_l), 16'h1);
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(0, 199) != 0);
      start      = ($urandom_range(0, 7) == 0);
      sample_en  = $urandom_range(0, 1) == 1;
      sin        = $urandom_range(0, 1) == 1;
      data_ready = ($urandom_range(0, 2) == 0);
      ovr_clr    = ($urandom_range(0, 15) == 0);
      step();
      check_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
